uart_rx_ctrl: RTL and testbench

- Receive-side controller placed between the uart_rx datapath and the host/bus side.
- Owns the active frame configuration (data bits, stop bits, parity enable, parity type) and drives it into uart_rx. Configuration changes only take effect between frames.
- Captures each received character, with its parity error flag, into a receive FIFO. Drives rts_n flow control with hysteresis.
- Reports overrun and receive timeout to the host.

---
 rtl/uart_pkg.sv | 45 ++++
 rtl/uart_rx_ctrl_if.sv | 37 +++
 rtl/uart_rx_fifo.sv | 60 ++++++
 rtl/uart_rx_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive controller.
//   cfg_t        : frame configuration {data_bit_num, stop_bit_num, parity_en, parity_type}
//   ctrl_state_t : controller FSM states
//   CFG_8N1      : configuration applied at reset
//   width_mask() : data-width code -> mask of the valid character bits
package uart_pkg;

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    typedef struct packed {
        logic [1:0] data_bit_num;
        logic       stop_bit_num;
        logic       parity_en;
        logic       parity_type;
    } cfg_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } ctrl_state_t;

    localparam cfg_t CFG_8N1 = '{
        data_bit_num: DBITS_8,
        stop_bit_num: 1'b0,
        parity_en:    1'b0,
        parity_type:  1'b0
    };

    function automatic logic [7:0] width_mask(input logic [1:0] code);
        logic [7:0] mask;
        mask = 8'hFF;
        unique case (code)
            DBITS_5: mask = 8'h1F;
            DBITS_6: mask = 8'h3F;
            DBITS_7: mask = 8'h7F;
            DBITS_8: mask = 8'hFF;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Host-side interface of the UART receive controller.
//   Config write : cfg_wr strobe with cfg_data_bit_num/cfg_stop_bit_num/cfg_parity_en/cfg_parity_type
//   Read port    : rd_valid/rd_ready handshake, rd_data/rd_perr head entry, level occupancy
//   Status       : overrun, timeout_irq, cleared by clr_err
// master = host side, slave = controller side.
interface uart_rx_ctrl_if #(
    parameter int unsigned FIFO_DEPTH = 16
);
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

    logic          cfg_wr;
    logic [1:0]    cfg_data_bit_num;
    logic          cfg_stop_bit_num;
    logic          cfg_parity_en;
    logic          cfg_parity_type;
    logic          rd_valid;
    logic          rd_ready;
    logic [7:0]    rd_data;
    logic          rd_perr;
    logic [LW-1:0] level;
    logic          overrun;
    logic          timeout_irq;
    logic          clr_err;

    modport master (
        output cfg_wr, cfg_data_bit_num, cfg_stop_bit_num, cfg_parity_en, cfg_parity_type,
        output rd_ready, clr_err,
        input  rd_valid, rd_data, rd_perr, level, overrun, timeout_irq
    );

    modport slave (
        input  cfg_wr, cfg_data_bit_num, cfg_stop_bit_num, cfg_parity_en, cfg_parity_type,
        input  rd_ready, clr_err,
        output rd_valid, rd_data, rd_perr, level, overrun, timeout_irq
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received characters.
//   push/wdata  : write request (accepted when not full, or full with a pop in the same cycle)
//   pop         : read request (ignored when empty)
//   rdata       : head entry; holds the last popped entry while empty
//   full/empty  : flags from pointers carrying one extra wrap bit
//   level       : current occupancy; level_next: occupancy after this clock edge
//   pop_ok      : a pop is actually taken this cycle
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 9,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned PW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PW-1:0]    level,
    output logic [PW-1:0]    level_next,
    output logic             pop_ok
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] last_q;
    logic             push_ok;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok     = pop && !empty;
    // A full FIFO still accepts a write when the head is leaving in the same cycle.
    assign push_ok    = push && (!full || pop_ok);
    assign level      = wr_ptr_q - rd_ptr_q;
    assign level_next = level + PW'(push_ok) - PW'(pop_ok);
    assign rdata      = empty ? last_q : mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                last_q   <= mem[rd_ptr_q[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller between the uart_rx datapath and the host.
//   clk, rst       : clock, asynchronous active-high reset
//   tick, rx_line  : 16x oversample strobe and synchronized rx pin (shared with uart_rx)
//   rx_done/rx_data/parity_error : character-complete pulse and its payload from uart_rx
//   data_bit_num/stop_bit_num/parity_en/parity_type : active frame config driven to uart_rx
//   rts_n          : flow control with hysteresis (0 = remote may send)
//   host           : config writes, FIFO read port, overrun/timeout status
// Config writes are staged and only applied while idle between frames.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned AF_THRESH     = 12,
    parameter int unsigned AE_THRESH     = 4,
    parameter int unsigned TIMEOUT_TICKS = 640
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       rx_line,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    input  logic       parity_error,
    output logic [1:0] data_bit_num,
    output logic       stop_bit_num,
    output logic       parity_en,
    output logic       parity_type,
    output logic       rts_n,
    uart_rx_ctrl_if.slave host
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_TICKS);

    ctrl_state_t   state_q, state_d;
    cfg_t          cfg_q, cfg_d;
    cfg_t          pend_cfg_q, pend_cfg_d;
    logic          pend_q, pend_d;
    logic          prev_rx_q;
    logic          fall;
    logic          rts_n_q, rts_n_d;
    logic          overrun_q, overrun_d;
    logic          timeout_q, timeout_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [8:0]    fifo_wdata, fifo_rdata;
    logic          fifo_full, fifo_empty, fifo_pop_ok;
    logic [LW-1:0] fifo_level, fifo_level_next;

    assign fall = prev_rx_q && !rx_line;

    // Characters are captured at the active width; parity errors only count when parity is on.
    assign fifo_wdata = {parity_error & cfg_q.parity_en, rx_data & width_mask(cfg_q.data_bit_num)};

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (rx_done),
        .wdata      (fifo_wdata),
        .pop        (host.rd_ready),
        .rdata      (fifo_rdata),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (fifo_level),
        .level_next (fifo_level_next),
        .pop_ok     (fifo_pop_ok)
    );

    // FSM and configuration staging.
    always_comb begin
        logic apply;
        state_d    = state_q;
        cfg_d      = cfg_q;
        pend_d     = pend_q;
        pend_cfg_d = pend_cfg_q;
        apply      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A starting frame wins; the staged config waits for the next idle gap.
                if (fall) begin
                    state_d = FRAME;
                end else if (pend_q) begin
                    cfg_d = pend_cfg_q;
                    apply = 1'b1;
                end
            end
            FRAME: begin
                if (rx_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (apply) pend_d = 1'b0;
        if (host.cfg_wr) begin
            pend_d     = 1'b1;
            pend_cfg_d = '{
                data_bit_num: host.cfg_data_bit_num,
                stop_bit_num: host.cfg_stop_bit_num,
                parity_en:    host.cfg_parity_en,
                parity_type:  host.cfg_parity_type
            };
        end
    end

    // Flow control, error status and idle timeout.
    always_comb begin
        logic to_set;
        rts_n_d = rts_n_q;
        if (fifo_level_next >= LW'(AF_THRESH)) begin
            rts_n_d = 1'b1;
        end else if (fifo_level_next <= LW'(AE_THRESH)) begin
            rts_n_d = 1'b0;
        end

        overrun_d = overrun_q;
        if (rx_done && fifo_full && !fifo_pop_ok) begin
            overrun_d = 1'b1;
        end else if (host.clr_err) begin
            overrun_d = 1'b0;
        end

        cnt_d = cnt_q;
        if (rx_done || fifo_pop_ok || fifo_empty) begin
            cnt_d = '0;
        end else if (tick && (state_q == IDLE) && (cnt_q != TO_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end

        to_set    = (cnt_d == TO_MAX) && (cnt_q != TO_MAX);
        timeout_d = timeout_q;
        if (to_set) begin
            timeout_d = 1'b1;
        end else if (fifo_pop_ok || (fifo_level_next == '0) || host.clr_err) begin
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cfg_q      <= CFG_8N1;
            pend_cfg_q <= CFG_8N1;
            pend_q     <= 1'b0;
            prev_rx_q  <= 1'b1;
            rts_n_q    <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            pend_cfg_q <= pend_cfg_d;
            pend_q     <= pend_d;
            prev_rx_q  <= rx_line;
            rts_n_q    <= rts_n_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
        end
    end

    assign data_bit_num = cfg_q.data_bit_num;
    assign stop_bit_num = cfg_q.stop_bit_num;
    assign parity_en    = cfg_q.parity_en;
    assign parity_type  = cfg_q.parity_type;
    assign rts_n        = rts_n_q;

    assign host.rd_valid    = !fifo_empty;
    assign host.rd_data     = fifo_rdata[7:0];
    assign host.rd_perr     = fifo_rdata[8];
    assign host.level       = fifo_level;
    assign host.overrun     = overrun_q;
    assign host.timeout_irq = timeout_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed testbench for uart_rx_ctrl (defaults: depth 16, AF 12, AE 4, timeout 640 ticks).
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       rx_line;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       parity_error;
  logic [1:0] data_bit_num;
  logic       stop_bit_num;
  logic       parity_en;
  logic       parity_type;
  logic       rts_n;

  int checks = 0;
  int errors = 0;

  uart_rx_ctrl_if #(.FIFO_DEPTH(16)) bus ();

  uart_rx_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .rx_line      (rx_line),
    .rx_done      (rx_done),
    .rx_data      (rx_data),
    .parity_error (parity_error),
    .data_bit_num (data_bit_num),
    .stop_bit_num (stop_bit_num),
    .parity_en    (parity_en),
    .parity_type  (parity_type),
    .rts_n        (rts_n),
    .host         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic p);
    rx_data      = d;
    parity_error = p;
    rx_done      = 1'b1;
    step();
    rx_done      = 1'b0;
    parity_error = 1'b0;
  endtask

  task automatic pop();
    bus.rd_ready = 1'b1;
    step();
    bus.rd_ready = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] db, input logic sb, input logic pe, input logic pt);
    bus.cfg_data_bit_num = db;
    bus.cfg_stop_bit_num = sb;
    bus.cfg_parity_en    = pe;
    bus.cfg_parity_type  = pt;
    bus.cfg_wr           = 1'b1;
    step();
    bus.cfg_wr           = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    tick = 1'b0;
    rx_line = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    parity_error = 1'b0;
    bus.cfg_wr = 1'b0;
    bus.cfg_data_bit_num = 2'b00;
    bus.cfg_stop_bit_num = 1'b0;
    bus.cfg_parity_en = 1'b0;
    bus.cfg_parity_type = 1'b0;
    bus.rd_ready = 1'b0;
    bus.clr_err = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_dbits", data_bit_num, 2'b11);
    chk("rst_sbits", stop_bit_num, 1'b0);
    chk("rst_pen", parity_en, 1'b0);
    chk("rst_ptype", parity_type, 1'b0);
    chk("rst_rts", rts_n, 1'b0);
    chk("rst_valid", bus.rd_valid, 1'b0);
    chk("rst_data", bus.rd_data, 8'h00);
    chk("rst_perr", bus.rd_perr, 1'b0);
    chk("rst_level", bus.level, 5'd0);
    chk("rst_ovr", bus.overrun, 1'b0);
    chk("rst_to", bus.timeout_irq, 1'b0);
    rst = 1'b0;
    step();

    // Single push and pop
    push(8'hA5, 1'b0);
    chk("push_valid", bus.rd_valid, 1'b1);
    chk("push_data", bus.rd_data, 8'hA5);
    chk("push_perr", bus.rd_perr, 1'b0);
    chk("push_level", bus.level, 5'd1);
    pop();
    chk("pop_level", bus.level, 5'd0);
    chk("pop_valid", bus.rd_valid, 1'b0);
    chk("empty_hold", bus.rd_data, 8'hA5);
    pop();
    chk("empty_pop", bus.level, 5'd0);

    // Config in IDLE: 5 data bits, parity on
    set_cfg(2'b00, 1'b0, 1'b1, 1'b0);
    chk("cfg5_dbits", data_bit_num, 2'b00);
    chk("cfg5_pen", parity_en, 1'b1);
    push(8'hFF, 1'b1);
    chk("mask5_data", bus.rd_data, 8'h1F);
    chk("mask5_perr", bus.rd_perr, 1'b1);
    pop();
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    chk("cfg8_dbits", data_bit_num, 2'b11);

    // Config write during a frame is deferred
    rx_line = 1'b0;
    step();
    chk("frame_state", dut.state_q, FRAME);
    bus.cfg_data_bit_num = 2'b10;
    bus.cfg_stop_bit_num = 1'b1;
    bus.cfg_parity_en    = 1'b1;
    bus.cfg_parity_type  = 1'b0;
    bus.cfg_wr = 1'b1;
    step();
    bus.cfg_wr = 1'b0;
    step();
    step();
    chk("frame_hold_db", data_bit_num, 2'b11);
    chk("frame_hold_pe", parity_en, 1'b0);
    rx_line = 1'b1;
    push(8'h3C, 1'b0);
    chk("done_hold_db", data_bit_num, 2'b11);
    // Fall in the first idle cycle: stays deferred
    rx_line = 1'b0;
    step();
    chk("fall_defer_db", data_bit_num, 2'b11);
    chk("fall_defer_sb", stop_bit_num, 1'b0);
    step();
    rx_line = 1'b1;
    push(8'hFF, 1'b1);
    chk("frame2_perr", bus.rd_perr, 1'b0);
    chk("frame2_hold", data_bit_num, 2'b11);
    step();
    chk("apply_db", data_bit_num, 2'b10);
    chk("apply_sb", stop_bit_num, 1'b1);
    chk("apply_pe", parity_en, 1'b1);
    chk("apply_pt", parity_type, 1'b0);
    chk("frame_head", bus.rd_data, 8'h3C);
    chk("frame_level", bus.level, 5'd2);
    pop();
    chk("frame_second", bus.rd_data, 8'hFF);
    pop();
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);

    // Fill, overrun, push+pop while full, hysteresis
    for (int i = 0; i < 11; i++) push(8'h10 + 8'(i), 1'b0);
    chk("lvl11_rts", rts_n, 1'b0);
    push(8'h1B, 1'b0);
    chk("lvl12_level", bus.level, 5'd12);
    chk("lvl12_rts", rts_n, 1'b1);
    for (int i = 12; i < 16; i++) push(8'h10 + 8'(i), 1'b0);
    chk("full_level", bus.level, 5'd16);
    chk("full_no_ovr", bus.overrun, 1'b0);
    push(8'h20, 1'b0);
    chk("ovr_level", bus.level, 5'd16);
    chk("ovr_set", bus.overrun, 1'b1);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    chk("clr_ovr", bus.overrun, 1'b0);
    rx_data = 8'h77;
    rx_done = 1'b1;
    bus.rd_ready = 1'b1;
    step();
    rx_done = 1'b0;
    bus.rd_ready = 1'b0;
    chk("pp_level", bus.level, 5'd16);
    chk("pp_no_ovr", bus.overrun, 1'b0);
    chk("pp_head", bus.rd_data, 8'h11);
    for (int i = 0; i < 11; i++) pop();
    chk("lvl5_level", bus.level, 5'd5);
    chk("lvl5_rts", rts_n, 1'b1);
    pop();
    chk("lvl4_rts", rts_n, 1'b0);
    chk("lvl4_head", bus.rd_data, 8'h1D);
    for (int i = 0; i < 4; i++) pop();
    chk("drain_level", bus.level, 5'd0);
    chk("drain_hold", bus.rd_data, 8'h77);

    // Receive timeout
    push(8'h55, 1'b0);
    for (int i = 0; i < 639; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
    chk("to_639", bus.timeout_irq, 1'b0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("to_640", bus.timeout_irq, 1'b1);
    pop();
    chk("to_pop", bus.timeout_irq, 1'b0);

    // Reset mid-frame with entries queued
    set_cfg(2'b10, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i), 1'b0);
    rx_line = 1'b0;
    step();
    chk("pre_rst_level", bus.level, 5'd5);
    #2 rst = 1'b1;
    #1;
    chk("mrst_level", bus.level, 5'd0);
    chk("mrst_valid", bus.rd_valid, 1'b0);
    chk("mrst_data", bus.rd_data, 8'h00);
    chk("mrst_rts", rts_n, 1'b0);
    chk("mrst_db", data_bit_num, 2'b11);
    chk("mrst_sb", stop_bit_num, 1'b0);
    chk("mrst_pe", parity_en, 1'b0);
    chk("mrst_state", dut.state_q, IDLE);
    step();
    rx_line = 1'b1;
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
